// File: rtl/i2s_rx_if.sv
// Stream/frame bundle between an I2S source, i2s_rx and the TDM transmitter.
// out_error exists only when I2S_RX_ERR_EN is defined.
interface i2s_rx_if #(
  parameter int unsigned G_BITS = 16
);
  logic              in_bclk;
  logic              in_lrclk;
  logic              in_din;
  logic [G_BITS-1:0] out_frame_1;
  logic [G_BITS-1:0] out_frame_2;
  logic              out_frame_strobe;
`ifdef I2S_RX_ERR_EN
  logic              out_error;

  modport slave (
    input  in_bclk, in_lrclk, in_din,
    output out_frame_1, out_frame_2, out_frame_strobe, out_error
  );
  modport master (
    output in_bclk, in_lrclk, in_din,
    input  out_frame_1, out_frame_2, out_frame_strobe, out_error
  );
`else
  modport slave (
    input  in_bclk, in_lrclk, in_din,
    output out_frame_1, out_frame_2, out_frame_strobe
  );
  modport master (
    output in_bclk, in_lrclk, in_din,
    input  out_frame_1, out_frame_2, out_frame_strobe
  );
`endif
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver oversampled in the mclk domain; emits each stereo pair with a one-cycle strobe.
// Optional sticky short-slot / missing-left flag when I2S_RX_ERR_EN is defined.
module i2s_rx #(
  parameter int unsigned G_BITS = 16
) (
  input logic     in_mclk,
  input logic     in_reset_n,
  i2s_rx_if.slave bus
);

  localparam int unsigned       CNT_W   = $clog2(G_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(G_BITS);
  localparam logic [G_BITS-1:0] MSB_ONE = {1'b1, {(G_BITS-1){1'b0}}};

  logic [1:0]        bclk_sync_q, lr_sync_q, din_sync_q;
  logic              bclk_prev_q;
  logic [G_BITS-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lr_prev_q, lr_prev_d;
  logic              aligned_q, aligned_d;
  logic              have_left_q, have_left_d;
  logic [G_BITS-1:0] left_hold_q, left_hold_d;
  logic [G_BITS-1:0] right_hold_q, right_hold_d;
  logic              pend_q, pend_d;
  logic [G_BITS-1:0] frame_1_q, frame_1_d;
  logic [G_BITS-1:0] frame_2_q, frame_2_d;
  logic              strobe_q, strobe_d;

  logic              edge_c, lr_s_c, din_s_c;
  logic [G_BITS-1:0] mask_c, word_bit_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  assign edge_c     = bclk_sync_q[1] & ~bclk_prev_q;
  assign lr_s_c     = lr_sync_q[1];
  assign din_s_c    = din_sync_q[1];
  // Shifting past the last slot bit yields an empty mask, which truncates long slots.
  assign mask_c     = MSB_ONE >> cnt_q;
  assign word_bit_c = din_s_c ? (word_q | mask_c) : word_q;
  assign cnt_inc_c  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef I2S_RX_ERR_EN
  logic err_q, err_d;
  logic short_c;
  assign short_c = (cnt_inc_c < CNT_MAX);
`endif

  // Bit capture, slot-end handling and output staging.
  always_comb begin
    word_d       = word_q;
    cnt_d        = cnt_q;
    lr_prev_d    = lr_prev_q;
    aligned_d    = aligned_q;
    have_left_d  = have_left_q;
    left_hold_d  = left_hold_q;
    right_hold_d = right_hold_q;
    pend_d       = 1'b0;
    frame_1_d    = frame_1_q;
    frame_2_d    = frame_2_q;
    strobe_d     = 1'b0;
`ifdef I2S_RX_ERR_EN
    err_d        = err_q;
`endif

    if (pend_q) begin
      frame_1_d = left_hold_q;
      frame_2_d = right_hold_q;
      strobe_d  = 1'b1;
    end

    if (edge_c) begin
      if (lr_s_c != lr_prev_q) begin
        // The bit just sampled closes the slot of channel lr_prev_q.
        if (!aligned_q) begin
          aligned_d = 1'b1;
        end else if (!lr_prev_q) begin
          left_hold_d = word_bit_c;
          have_left_d = 1'b1;
        end else if (have_left_q) begin
          right_hold_d = word_bit_c;
          pend_d       = 1'b1;
          have_left_d  = 1'b0;
        end
`ifdef I2S_RX_ERR_EN
        if (aligned_q && (short_c || (lr_prev_q && !have_left_q))) begin
          err_d = 1'b1;
        end
`endif
        word_d    = '0;
        cnt_d     = '0;
        lr_prev_d = lr_s_c;
      end else begin
        word_d = word_bit_c;
        cnt_d  = cnt_inc_c;
      end
    end
  end

  always_ff @(posedge in_mclk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      bclk_sync_q  <= '0;
      lr_sync_q    <= '0;
      din_sync_q   <= '0;
      bclk_prev_q  <= 1'b0;
      word_q       <= '0;
      cnt_q        <= '0;
      lr_prev_q    <= 1'b0;
      aligned_q    <= 1'b0;
      have_left_q  <= 1'b0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      pend_q       <= 1'b0;
      frame_1_q    <= '0;
      frame_2_q    <= '0;
      strobe_q     <= 1'b0;
`ifdef I2S_RX_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      bclk_sync_q  <= {bclk_sync_q[0], bus.in_bclk};
      lr_sync_q    <= {lr_sync_q[0], bus.in_lrclk};
      din_sync_q   <= {din_sync_q[0], bus.in_din};
      bclk_prev_q  <= bclk_sync_q[1];
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      lr_prev_q    <= lr_prev_d;
      aligned_q    <= aligned_d;
      have_left_q  <= have_left_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      pend_q       <= pend_d;
      frame_1_q    <= frame_1_d;
      frame_2_q    <= frame_2_d;
      strobe_q     <= strobe_d;
`ifdef I2S_RX_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  assign bus.out_frame_1      = frame_1_q;
  assign bus.out_frame_2      = frame_2_q;
  assign bus.out_frame_strobe = strobe_q;
`ifdef I2S_RX_ERR_EN
  assign bus.out_error        = err_q;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: table of single-pair slot-width cases plus
// hand-written reset-alignment, continuous-stream and mid-slot-reset sequences.
module tb_i2s_rx;

  localparam int unsigned G_BITS = 16;

  typedef struct {
    int unsigned nbits;
    logic [31:0] left;
    logic [31:0] right;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } vec_t;

  typedef struct {
    logic [15:0] f1;
    logic [15:0] f2;
    int          cyc;
  } cap_t;

  typedef struct packed {
    logic ch;
    logic d;
  } sbit_t;

  logic  mclk = 1'b0;
  logic  rst_n = 1'b0;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  cap_t  caps[$];
  sbit_t stream[$];
  int    rise_cyc[512];

  i2s_rx_if #(.G_BITS(G_BITS)) bus ();

  i2s_rx #(.G_BITS(G_BITS)) u_dut (
    .in_mclk    (mclk),
    .in_reset_n (rst_n),
    .bus        (bus)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  always @(negedge mclk) begin
    if (bus.out_frame_strobe === 1'b1) begin
      caps.push_back('{f1: bus.out_frame_1, f2: bus.out_frame_2, cyc: cyc});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_slot(input logic ch, input logic [31:0] val, input int n);
    for (int b = n - 1; b >= 0; b--) stream.push_back('{ch: ch, d: val[b]});
  endtask

  // Clears state and holds reset; optionally releases it after a few cycles.
  task automatic start_test(input bit release_rst);
    rst_n       = 1'b0;
    bus.in_bclk = 1'b0;
    bus.in_lrclk = 1'b0;
    bus.in_din  = 1'b0;
    stream.delete();
    repeat (3) @(negedge mclk);
    caps.delete();
    if (release_rst) rst_n = 1'b1;
  endtask

  // lrclk leads data by one bit period, so period i carries the data of bit i
  // and the channel of bit i+1; each bclk phase lasts 4 mclk.
  task automatic run_stream(input int rst_assert_at, input int rst_release_at);
    int n;
    n = stream.size();
    for (int i = 0; i < n; i++) begin
      @(negedge mclk);
      bus.in_bclk = 1'b0;
      if (i == rst_assert_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_frame_1", 32'(bus.out_frame_1), 32'h0);
        check("rst_mid_frame_2", 32'(bus.out_frame_2), 32'h0);
        check("rst_mid_strobe", 32'(bus.out_frame_strobe), 32'h0);
      end
      if (i == rst_release_at) rst_n = 1'b1;
      bus.in_lrclk = (i + 1 < n) ? stream[i+1].ch : stream[i].ch;
      bus.in_din   = stream[i].d;
      repeat (3) @(negedge mclk);
      @(negedge mclk);
      bus.in_bclk = 1'b1;
      rise_cyc[i] = cyc;
      repeat (3) @(negedge mclk);
    end
    @(negedge mclk);
    bus.in_bclk = 1'b0;
    repeat (20) @(negedge mclk);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{nbits: 16, left: 32'h0000A5C3, right: 32'h00001234, exp1: 16'hA5C3, exp2: 16'h1234};
    vecs[1] = '{nbits: 24, left: 32'h00ABCDEF, right: 32'h00123456, exp1: 16'hABCD, exp2: 16'h1234};
    vecs[2] = '{nbits: 12, left: 32'h00000FFF, right: 32'h00000800, exp1: 16'hFFF0, exp2: 16'h8000};
    vecs[3] = '{nbits: 16, left: 32'h0000FFFF, right: 32'h00000001, exp1: 16'hFFFF, exp2: 16'h0001};
    vecs[4] = '{nbits: 17, left: 32'h00010001, right: 32'h0000FFFF, exp1: 16'h8000, exp2: 16'h7FFF};

    // Reset state.
    start_test(1'b0);
    check("reset_frame_1", 32'(bus.out_frame_1), 32'h0);
    check("reset_frame_2", 32'(bus.out_frame_2), 32'h0);
    check("reset_strobe", 32'(bus.out_frame_strobe), 32'h0);
`ifdef I2S_RX_ERR_EN
    check("reset_error", 32'(bus.out_error), 32'h0);
`endif

    // Alignment slot (right), then one L/R pair, then a short left tail.
    for (int v = 0; v < 5; v++) begin
      int n;
      n = int'(vecs[v].nbits);
      start_test(1'b1);
      push_slot(1'b1, 32'h0, n);
      push_slot(1'b0, vecs[v].left, n);
      push_slot(1'b1, vecs[v].right, n);
      push_slot(1'b0, 32'h0, 4);
      run_stream(-1, -1);
      check($sformatf("vec%0d_strobes", v), 32'(caps.size()), 32'd1);
      if (caps.size() > 0) begin
        check($sformatf("vec%0d_frame_1", v), 32'(caps[0].f1), 32'(vecs[v].exp1));
        check($sformatf("vec%0d_frame_2", v), 32'(caps[0].f2), 32'(vecs[v].exp2));
        check($sformatf("vec%0d_latency", v), 32'(caps[0].cyc - rise_cyc[3*n-1]), 32'd4);
      end
`ifdef I2S_RX_ERR_EN
      if (vecs[v].nbits < G_BITS) check($sformatf("vec%0d_error", v), 32'(bus.out_error), 32'h1);
`endif
    end

    // Reset released mid right slot: first strobe is the first full L then R pair.
    start_test(1'b0);
    push_slot(1'b1, 32'h0000AAAA, 16);
    push_slot(1'b0, 32'h00000F0F, 16);
    push_slot(1'b1, 32'h0000F0F0, 16);
    push_slot(1'b0, 32'h00001357, 16);
    push_slot(1'b1, 32'h00002468, 16);
    push_slot(1'b0, 32'h0, 4);
    run_stream(-1, 8);
    check("realign_strobes", 32'(caps.size()), 32'd2);
    if (caps.size() >= 2) begin
      check("realign_p0_frame_1", 32'(caps[0].f1), 32'h0F0F);
      check("realign_p0_frame_2", 32'(caps[0].f2), 32'hF0F0);
      check("realign_p1_frame_1", 32'(caps[1].f1), 32'h1357);
      check("realign_p1_frame_2", 32'(caps[1].f2), 32'h2468);
    end

    // Continuous stream of four pairs: one strobe per 32 bits x 8 mclk.
    begin
      logic [15:0] l_exp[4];
      logic [15:0] r_exp[4];
      l_exp = '{16'h1111, 16'hBEEF, 16'h8001, 16'h0000};
      r_exp = '{16'h2222, 16'hCAFE, 16'h7FFE, 16'hFFFF};
      start_test(1'b1);
      push_slot(1'b1, 32'h0, 16);
      for (int k = 0; k < 4; k++) begin
        push_slot(1'b0, 32'(l_exp[k]), 16);
        push_slot(1'b1, 32'(r_exp[k]), 16);
      end
      push_slot(1'b0, 32'h0, 4);
      run_stream(-1, -1);
      check("stream_strobes", 32'(caps.size()), 32'd4);
      if (caps.size() >= 4) begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("stream_p%0d_frame_1", k), 32'(caps[k].f1), 32'(l_exp[k]));
          check($sformatf("stream_p%0d_frame_2", k), 32'(caps[k].f2), 32'(r_exp[k]));
          if (k > 0) check($sformatf("stream_p%0d_spacing", k), 32'(caps[k].cyc - caps[k-1].cyc), 32'd256);
        end
      end
    end

    // Reset mid left slot after a strobe: outputs clear, next full pair is output.
    start_test(1'b1);
    push_slot(1'b1, 32'h0, 16);
    push_slot(1'b0, 32'h00001111, 16);
    push_slot(1'b1, 32'h00002222, 16);
    push_slot(1'b0, 32'h00003333, 16);
    push_slot(1'b1, 32'h00004444, 16);
    push_slot(1'b0, 32'h00005555, 16);
    push_slot(1'b1, 32'h00006666, 16);
    push_slot(1'b0, 32'h0, 4);
    run_stream(52, 56);
    check("midrst_strobes", 32'(caps.size()), 32'd2);
    if (caps.size() >= 2) begin
      check("midrst_p0_frame_1", 32'(caps[0].f1), 32'h1111);
      check("midrst_p0_frame_2", 32'(caps[0].f2), 32'h2222);
      check("midrst_p1_frame_1", 32'(caps[1].f1), 32'h5555);
      check("midrst_p1_frame_2", 32'(caps[1].f2), 32'h6666);
    end
    check("midrst_hold_frame_1", 32'(bus.out_frame_1), 32'h5555);
    check("midrst_hold_strobe", 32'(bus.out_frame_strobe), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
